// File: rtl/system_pkg.sv
// Shared definitions for the TX response path: FSM state encoding and default sizing.
package system_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_LOW = 2'd2,
        DRAIN    = 2'd3
    } tx_state_e;

    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_FIFO_DEPTH   = 8;
    localparam int unsigned DEF_BUSY_TIMEOUT = 64;

endpackage

// File: rtl/tx_response_fifo_if.sv
// Push-side and transmitter-side handshake between the system controller and the TX response FIFO.
interface tx_response_fifo_if
    import system_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  wr_data_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ready;
    logic                  transmitter_busy_sync;
    logic                  transmitter_parallel_data_valid;
    logic [DATA_WIDTH-1:0] transmitter_parallel_data;

    modport master (
        output wr_data_valid,
        output wr_data,
        input  wr_ready,
        output transmitter_busy_sync,
        input  transmitter_parallel_data_valid,
        input  transmitter_parallel_data
    );

    modport slave (
        input  wr_data_valid,
        input  wr_data,
        output wr_ready,
        input  transmitter_busy_sync,
        output transmitter_parallel_data_valid,
        output transmitter_parallel_data
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// Circular byte store with wrapping read/write pointers; full/empty derived from the occupancy count.
module sync_fifo_mem
    import system_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push_valid,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [DATA_WIDTH-1:0]         head_data
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;

    assign full      = (fill_level == FULL_LEVEL);
    assign empty     = (fill_level == '0);
    // A push against a full store is dropped here even if a pop lands in the same cycle.
    assign push      = push_valid && !full;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fill_level <= fill_level + 1'b1;
            end else if (!push && pop) begin
                fill_level <= fill_level - 1'b1;
            end
        end
    end
endmodule

// File: rtl/tx_response_fifo.sv
// Buffers response bytes and hands them one at a time to the UART transmitter, with busy timeout and sticky errors.
module tx_response_fifo
    import system_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    tx_response_fifo_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0] fill_level,
    input  logic                        clear_errors,
    output logic                        overflow_error,
    output logic                        timeout_error
);
    localparam int unsigned TO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    tx_state_e             state;
    tx_state_e             next_state;
    logic [TO_W-1:0]       to_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  timeout_set;
    logic                  overflow_set;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (bus.wr_data_valid),
        .push_data  (bus.wr_data),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .fill_level (fill_level),
        .head_data  (head_data)
    );

    assign bus.wr_ready                        = !full;
    assign bus.transmitter_parallel_data_valid = (state == ISSUE);
    assign bus.transmitter_parallel_data       = data_q;
    assign overflow_set                        = bus.wr_data_valid && full;

    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && !bus.transmitter_busy_sync) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                // An acknowledge on the final counted cycle still wins over the timeout.
                if (bus.transmitter_busy_sync) begin
                    next_state = WAIT_LOW;
                end else if (to_cnt == TO_LAST) begin
                    next_state  = DRAIN;
                    timeout_set = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!bus.transmitter_busy_sync) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                pop        = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            to_cnt         <= '0;
            data_q         <= '0;
            overflow_error <= 1'b0;
            timeout_error  <= 1'b0;
        end else begin
            state  <= next_state;
            to_cnt <= (state == ISSUE && next_state == ISSUE) ? to_cnt + 1'b1 : '0;
            // The head cannot move while issuing, so reloading it every ISSUE cycle keeps data stable.
            data_q <= (next_state == ISSUE) ? head_data : '0;
            if (overflow_set) begin
                overflow_error <= 1'b1;
            end else if (clear_errors) begin
                overflow_error <= 1'b0;
            end
            if (timeout_set) begin
                timeout_error <= 1'b1;
            end else if (clear_errors) begin
                timeout_error <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tx_response_fifo.sv
// Directed scenarios plus randomized traffic checked against a queue-based model of the TX response FIFO.
module tb_tx_response_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 64;

    logic       clk;
    logic       reset_n;
    logic       clear_errors;
    logic [3:0] fill_level;
    logic       overflow_error;
    logic       timeout_error;

    tx_response_fifo_if #(.DATA_WIDTH(DW)) bus ();

    tx_response_fifo #(
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus.slave),
        .fill_level     (fill_level),
        .clear_errors   (clear_errors),
        .overflow_error (overflow_error),
        .timeout_error  (timeout_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;
    string       scen;

    // Reference model: byte queue plus the offer/acknowledge/retire progress of the head byte.
    logic [7:0]  mq[$];
    bit          m_offering;
    bit          m_acked;
    bit          m_retiring;
    int          m_age;
    bit          m_ovf;
    bit          m_tmo;

    logic [7:0]  issued[$];
    int          valid_cycles;
    bit          prev_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", scen, tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_offering = 0;
        m_acked    = 0;
        m_retiring = 0;
        m_age      = 0;
        m_ovf      = 0;
        m_tmo      = 0;
        prev_valid = 0;
    endtask

    task automatic compare_all();
        check("valid", bus.transmitter_parallel_data_valid, m_offering);
        check("data", bus.transmitter_parallel_data, m_offering ? mq[0] : 8'h00);
        check("fill", fill_level, mq.size());
        check("wr_ready", bus.wr_ready, (mq.size() < DEPTH));
        check("ovf", overflow_error, m_ovf);
        check("tmo", timeout_error, m_tmo);
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit busy, input bit clr);
        bit is_full;
        bit do_pop;
        bit set_tmo;
        bus.wr_data_valid          = v;
        bus.wr_data                = d;
        bus.transmitter_busy_sync  = busy;
        clear_errors               = clr;
        is_full = (mq.size() == DEPTH);
        do_pop  = m_retiring;
        set_tmo = 0;
        if (m_retiring) begin
            m_retiring = 0;
        end else if (m_offering) begin
            if (busy) begin
                m_offering = 0;
                m_acked    = 1;
            end else if (m_age + 1 == TMO) begin
                m_offering = 0;
                m_retiring = 1;
                set_tmo    = 1;
            end else begin
                m_age++;
            end
        end else if (m_acked) begin
            if (!busy) begin
                m_acked    = 0;
                m_retiring = 1;
            end
        end else if (mq.size() > 0 && !busy) begin
            m_offering = 1;
            m_age      = 0;
        end
        if (do_pop) void'(mq.pop_front());
        if (v && !is_full) mq.push_back(d);
        m_ovf = (v && is_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_tmo = set_tmo ? 1'b1 : (clr ? 1'b0 : m_tmo);
        @(posedge clk);
        #1;
        compare_all();
        if (bus.transmitter_parallel_data_valid) valid_cycles++;
        if (bus.transmitter_parallel_data_valid && !prev_valid) issued.push_back(bus.transmitter_parallel_data);
        prev_valid = bus.transmitter_parallel_data_valid;
    endtask

    task automatic idle_inputs();
        bus.wr_data_valid         = 0;
        bus.wr_data               = '0;
        bus.transmitter_busy_sync = 0;
        clear_errors              = 0;
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset();
        #3;
        reset_n = 0;
        #1;
        check("rst_valid", bus.transmitter_parallel_data_valid, 0);
        check("rst_data", bus.transmitter_parallel_data, 0);
        check("rst_fill", fill_level, 0);
        check("rst_ready", bus.wr_ready, 1);
        check("rst_ovf", overflow_error, 0);
        check("rst_tmo", timeout_error, 0);
        model_clear();
        idle_inputs();
        @(posedge clk);
        #2;
        reset_n = 1;
    endtask

    logic [7:0] first_byte;
    bit         rb;

    initial begin
        n_cmp = 0;
        n_err = 0;
        valid_cycles = 0;
        scen = "reset";
        reset_n = 0;
        idle_inputs();
        model_clear();
        #12;
        check("valid", bus.transmitter_parallel_data_valid, 0);
        check("fill", fill_level, 0);
        check("wr_ready", bus.wr_ready, 1);
        check("ovf", overflow_error, 0);
        check("tmo", timeout_error, 0);
        @(negedge clk);
        reset_n = 1;

        // Scenario 1: acknowledged transfer
        scen = "s1";
        valid_cycles = 0;
        issued.delete();
        cycle(1, 8'hA5, 0, 0);
        check("fill_after_push", fill_level, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        repeat (10) cycle(0, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 0);
        first_byte = (issued.size() > 0) ? issued[0] : 8'h00;
        check("valid_cycles", valid_cycles, 3);
        check("issue_count", issued.size(), 1);
        check("issued_byte", first_byte, 8'hA5);
        check("fill_end", fill_level, 0);

        // Scenario 2: fill, overflow, in-order drain by timeouts
        scen = "s2";
        async_reset();
        issued.delete();
        for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0, 0);
        check("ready_full", bus.wr_ready, 0);
        cycle(1, 8'hFF, 0, 0);
        check("ovf_set", overflow_error, 1);
        repeat (600) cycle(0, 0, 0, 0);
        check("issue_count", issued.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("order", (i < issued.size()) ? 32'(issued[i]) : 32'hDEAD, i + 1);
        end
        check("fill_end", fill_level, 0);
        check("tmo_end", timeout_error, 1);

        // Scenario 3: single byte never acknowledged
        scen = "s3";
        async_reset();
        issued.delete();
        valid_cycles = 0;
        cycle(1, 8'h3C, 0, 0);
        repeat (80) cycle(0, 0, 0, 0);
        check("valid_cycles", valid_cycles, TMO);
        check("issue_count", issued.size(), 1);
        check("tmo_set", timeout_error, 1);
        check("fill_end", fill_level, 0);

        // Scenario 4: push coinciding with the pop keeps occupancy
        scen = "s4";
        async_reset();
        cycle(1, 8'h11, 1, 0);
        cycle(1, 8'h22, 1, 0);
        cycle(1, 8'h33, 1, 0);
        check("fill_three", fill_level, 3);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 8'h44, 0, 0);
        check("fill_stays", fill_level, 3);
        repeat (4) cycle(0, 0, 1, 0);

        // Scenario 5: reset during an issue with both flags set
        scen = "s5";
        async_reset();
        repeat (9) cycle(1, 8'($urandom), 1, 0);
        cycle(0, 0, 0, 0);
        check("issuing", bus.transmitter_parallel_data_valid, 1);
        cycle(0, 0, 0, 0);
        async_reset();
        repeat (3) cycle(0, 0, 0, 0);

        // Scenario 6: overflow beats a simultaneous clear
        scen = "s6";
        for (int i = 0; i < 8; i++) cycle(1, 8'(i + 8'h50), 1, 0);
        cycle(1, 8'hEE, 1, 1);
        check("ovf_priority", overflow_error, 1);
        cycle(0, 0, 1, 1);
        check("ovf_cleared", overflow_error, 0);

        // Randomized traffic against the model
        scen = "rand";
        async_reset();
        rb = 0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) == 0) rb = ~rb;
            cycle(($urandom_range(0, 4) < 2), 8'($urandom), rb, ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tx_response_fifo.md
TX_RESPONSE_FIFO -- requirements
Module: tx_response_fifo

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, reset_n; reset_n SHALL be asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the byte width.
REQ-003 Parameter FIFO_DEPTH, default 8, SHALL set the number of entries and SHALL be a power of two and at least 2.
REQ-004 Parameter BUSY_TIMEOUT, default 64, SHALL set the number of cycles to wait for the transmitter to acknowledge a byte.
REQ-005 Port clk, input, 1 bit: rising-edge clock (the ref_clk domain).
REQ-006 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port wr_data_valid, input, 1 bit: single-cycle push strobe from the system controller.
REQ-008 Port wr_data, input, DATA_WIDTH bits: byte to push.
REQ-009 Port wr_ready, output, 1 bit: high when the FIFO is not full.
REQ-010 Port transmitter_busy_sync, input, 1 bit: UART transmitter busy flag, already synchronized into clk.
REQ-011 Port transmitter_parallel_data_valid, output, 1 bit: level-held issue request toward the UART-domain data synchronizer.
REQ-012 Port transmitter_parallel_data, output, DATA_WIDTH bits: byte being issued.
REQ-013 Port fill_level, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-014 Port clear_errors, input, 1 bit: synchronous clear of the sticky error flags.
REQ-015 Port overflow_error, output, 1 bit: sticky flag, set when a push was dropped.
REQ-016 Port timeout_error, output, 1 bit: sticky flag, set when a byte was discarded after a timeout.

Function
REQ-017 A push (wr_data_valid=1 while wr_ready=1) SHALL write wr_data at the write pointer and increment fill_level on the next edge.
REQ-018 A push while full SHALL be dropped and SHALL set overflow_error, even if a pop occurs in the same cycle.
REQ-019 A push and a pop in the same cycle with the FIFO not full SHALL leave fill_level unchanged.
REQ-020 Both pointers SHALL wrap from FIFO_DEPTH-1 to 0; full/empty SHALL be derived from fill_level.
REQ-021 The FSM SHALL implement four states: IDLE, ISSUE, WAIT_LOW and DRAIN.
REQ-022 IDLE->ISSUE SHALL occur when the FIFO is not empty and transmitter_busy_sync=0.
REQ-023 In ISSUE, transmitter_parallel_data_valid=1 and transmitter_parallel_data SHALL equal the head entry, held stable.
REQ-024 ISSUE->WAIT_LOW SHALL occur on the first cycle transmitter_busy_sync=1; valid SHALL deassert in WAIT_LOW.
REQ-025 ISSUE SHALL count cycles; after BUSY_TIMEOUT cycles without busy, the FSM SHALL go ISSUE->DRAIN and set timeout_error.
REQ-026 WAIT_LOW->DRAIN SHALL occur when transmitter_busy_sync returns to 0.
REQ-027 DRAIN SHALL pop the head entry for exactly one cycle and return to IDLE.
REQ-028 An empty FIFO SHALL never issue, so the minimum spacing between issues SHALL be 4 cycles.
REQ-029 transmitter_parallel_data SHALL be registered and SHALL be 0 outside ISSUE.
REQ-030 clear_errors=1 SHALL clear both flags on the next edge; a same-cycle set SHALL take priority over clear.

Reset
REQ-031 On reset_n=0, with immediate asynchronous effect: FSM to IDLE; pointers, fill_level and timeout counter to 0; wr_ready=1; all other outputs 0.
REQ-032 A reset asserted in ISSUE or WAIT_LOW SHALL abandon the in-flight byte with no pop and no error flag set.
REQ-033 Storage contents need not be reset.

Structure
REQ-034 The FSM state encodings and the default parameter constants SHALL reside in the shared package system_pkg.
REQ-035 Storage and pointer logic SHALL be a single sub-module, sync_fifo_mem; the FSM and error flags SHALL be in tx_response_fifo.

Verification
REQ-036 Scenario 1: push 0xA5, then raise busy 3 cycles after valid and hold it 10 cycles -> valid high for exactly 3 cycles with data 0xA5, one pop, fill_level 1->0.
REQ-037 Scenario 2: push 8 bytes 0x01..0x08 with busy tied low -> wr_ready=0 after the 8th push; a 9th push 0xFF sets overflow_error; after timeouts, bytes issue in order 0x01..0x08.
REQ-038 Scenario 3: push 0x3C with busy never rising -> valid high for 64 cycles, then timeout_error=1, fill_level=0, FSM in IDLE.
REQ-039 Scenario 4: with the FIFO holding 3 bytes, push during a DRAIN cycle -> fill_level stays 3.
REQ-040 Scenario 5: assert reset_n=0 mid-ISSUE -> valid=0 immediately, fill_level=0, both flags 0.
REQ-041 Scenario 6: assert clear_errors in the same cycle as an overflow push -> overflow_error remains 1.
